// File: rtl/jogo_pkg.sv
// Shared definitions for the memory game: FSM state codes and button index/one-hot helpers.
// Helpers work on a 32-bit window, so designs built on them support up to 32 buttons.
package jogo_pkg;

  typedef enum logic [4:0] {
    INICIAL       = 5'd0,
    PREPARA       = 5'd1,
    ESPERA_NOVA   = 5'd2,
    GRAVA         = 5'd3,
    MOSTRA        = 5'd4,
    APAGA         = 5'd5,
    ESPERA_JOGADA = 5'd6,
    COMPARA       = 5'd7,
    FIM_ACERTOU   = 5'd8,
    FIM_ERROU     = 5'd9,
    FIM_TIMEOUT   = 5'd10
  } estado_t;

  localparam int MAX_LARGURA = 32;

  function automatic logic [MAX_LARGURA-1:0] indice_para_onehot(input logic [4:0] idx);
    indice_para_onehot      = '0;
    indice_para_onehot[idx] = 1'b1;
  endfunction

  function automatic logic [4:0] onehot_para_indice(input logic [MAX_LARGURA-1:0] v);
    onehot_para_indice = '0;
    for (int i = 0; i < MAX_LARGURA; i++) begin
      if (v[i]) onehot_para_indice = 5'(i);
    end
  endfunction

  function automatic logic eh_onehot(input logic [MAX_LARGURA-1:0] v);
    return (v != '0) && ((v & (v - MAX_LARGURA'(1))) == '0);
  endfunction

endpackage

// File: rtl/jogo_memoria_param_contador.sv
// Modulo-MODULO up counter with synchronous clear (zera) over count (conta); fim flags the last value.
module contador_m #(
  parameter int MODULO  = 4,
  parameter int LARGURA = (MODULO > 1) ? $clog2(MODULO) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               zera_i,
  input  logic               conta_i,
  output logic [LARGURA-1:0] valor_o,
  output logic               fim_o
);

  logic [LARGURA-1:0] valor_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor_q <= '0;
    end else if (zera_i) begin
      valor_q <= '0;
    end else if (conta_i) begin
      valor_q <= (valor_q == LARGURA'(MODULO - 1)) ? '0 : valor_q + LARGURA'(1);
    end
  end

  assign valor_o = valor_q;
  assign fim_o   = (valor_q == LARGURA'(MODULO - 1));

endmodule

// File: rtl/jogo_memoria_param.sv
// Memory game top: stores a growing button sequence, plays it back on the LEDs and checks the repetition.
// Define JOGO_TIMEOUT_EN to add the per-move timeout counter and the FIM_TIMEOUT outcome.
module jogo_memoria_param
  import jogo_pkg::*;
#(
  parameter int NUM_BOTOES     = 4,
  parameter int MAX_RODADAS    = 16,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int LED_CICLOS     = 1000,
  localparam int IW = $clog2(NUM_BOTOES),
  localparam int RW = $clog2(MAX_RODADAS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  jogar,
  input  logic [NUM_BOTOES-1:0] botoes,
  output logic [NUM_BOTOES-1:0] leds,
  output logic                  pronto,
  output logic                  acertou,
  output logic                  errou,
  output logic                  timeout,
  output logic [RW-1:0]         rodada,
  output logic [4:0]            db_estado,
  output logic [IW-1:0]         db_jogada
);

  localparam int AW = (MAX_RODADAS > 1) ? $clog2(MAX_RODADAS) : 1;

  estado_t         estado_q;
  logic [RW-1:0]   rodada_q;
  logic            pronto_q, acertou_q, errou_q;
  logic            botao_ant_q, mv_q, mv_ok_q;
  logic [IW-1:0]   jogada_q;
  logic [IW-1:0]   mem_q [MAX_RODADAS];

  logic            espera, fase_led, borda, ultimo, acerto;
  logic            zera_e, conta_e, led_fim;
  logic [AW-1:0]   e_valor;
  logic            e_fim_unused;
  logic [(LED_CICLOS > 1 ? $clog2(LED_CICLOS) : 1)-1:0] led_valor_unused;

  assign espera   = (estado_q == ESPERA_NOVA) || (estado_q == ESPERA_JOGADA);
  assign fase_led = (estado_q == MOSTRA) || (estado_q == APAGA);
  assign borda    = (|botoes) && !botao_ant_q;
  assign ultimo   = (RW'(e_valor) + RW'(1)) == rodada_q;
  assign acerto   = mv_ok_q && (mem_q[e_valor] == jogada_q);

  // Only edges seen while waiting for the player become moves; playback presses are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      botao_ant_q <= 1'b0;
      mv_q        <= 1'b0;
      mv_ok_q     <= 1'b0;
      jogada_q    <= '0;
    end else begin
      botao_ant_q <= |botoes;
      mv_q        <= borda && espera;
      if (borda && espera) begin
        mv_ok_q <= eh_onehot(MAX_LARGURA'(botoes));
        if (eh_onehot(MAX_LARGURA'(botoes))) begin
          jogada_q <= IW'(onehot_para_indice(MAX_LARGURA'(botoes)));
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (estado_q == GRAVA) mem_q[AW'(rodada_q)] <= jogada_q;
  end

  assign zera_e  = (estado_q == PREPARA) || (estado_q == GRAVA) ||
                   ((estado_q == APAGA) && led_fim && ultimo);
  assign conta_e = ((estado_q == APAGA) && led_fim && !ultimo) ||
                   ((estado_q == COMPARA) && acerto && !ultimo);

  contador_m #(.MODULO(MAX_RODADAS)) u_endereco (
    .clock(clock), .reset(reset), .zera_i(zera_e), .conta_i(conta_e),
    .valor_o(e_valor), .fim_o(e_fim_unused)
  );

  contador_m #(.MODULO(LED_CICLOS)) u_led (
    .clock(clock), .reset(reset), .zera_i(!fase_led || led_fim), .conta_i(fase_led),
    .valor_o(led_valor_unused), .fim_o(led_fim)
  );

`ifdef JOGO_TIMEOUT_EN
  logic timeout_q, tmo_fim;
  logic [(TIMEOUT_CICLOS > 1 ? $clog2(TIMEOUT_CICLOS) : 1)-1:0] tmo_valor_unused;

  contador_m #(.MODULO(TIMEOUT_CICLOS)) u_timeout (
    .clock(clock), .reset(reset), .zera_i(!espera || mv_q), .conta_i(espera),
    .valor_o(tmo_valor_unused), .fim_o(tmo_fim)
  );

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Main game FSM; final-state flags are set on entry and cleared when a new game starts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= INICIAL;
      rodada_q  <= '0;
      pronto_q  <= 1'b0;
      acertou_q <= 1'b0;
      errou_q   <= 1'b0;
`ifdef JOGO_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      case (estado_q)
        INICIAL: if (jogar) estado_q <= PREPARA;
        PREPARA: begin
          rodada_q <= '0;
          estado_q <= ESPERA_NOVA;
        end
        ESPERA_NOVA: begin
          if (mv_q) begin
            if (mv_ok_q) begin
              estado_q <= GRAVA;
            end else begin
              estado_q <= FIM_ERROU;
              pronto_q <= 1'b1;
              errou_q  <= 1'b1;
            end
`ifdef JOGO_TIMEOUT_EN
          end else if (tmo_fim) begin
            estado_q  <= FIM_TIMEOUT;
            pronto_q  <= 1'b1;
            errou_q   <= 1'b1;
            timeout_q <= 1'b1;
`endif
          end
        end
        GRAVA: begin
          rodada_q <= rodada_q + RW'(1);
          estado_q <= MOSTRA;
        end
        MOSTRA: if (led_fim) estado_q <= APAGA;
        APAGA:  if (led_fim) estado_q <= ultimo ? ESPERA_JOGADA : MOSTRA;
        ESPERA_JOGADA: begin
          if (mv_q) begin
            estado_q <= COMPARA;
`ifdef JOGO_TIMEOUT_EN
          end else if (tmo_fim) begin
            estado_q  <= FIM_TIMEOUT;
            pronto_q  <= 1'b1;
            errou_q   <= 1'b1;
            timeout_q <= 1'b1;
`endif
          end
        end
        COMPARA: begin
          if (!acerto) begin
            estado_q <= FIM_ERROU;
            pronto_q <= 1'b1;
            errou_q  <= 1'b1;
          end else if (!ultimo) begin
            estado_q <= ESPERA_JOGADA;
          end else if (rodada_q == RW'(MAX_RODADAS)) begin
            estado_q  <= FIM_ACERTOU;
            pronto_q  <= 1'b1;
            acertou_q <= 1'b1;
          end else begin
            estado_q <= ESPERA_NOVA;
          end
        end
        FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
          if (jogar) begin
            estado_q  <= PREPARA;
            rodada_q  <= '0;
            pronto_q  <= 1'b0;
            acertou_q <= 1'b0;
            errou_q   <= 1'b0;
`ifdef JOGO_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        default: estado_q <= INICIAL;
      endcase
    end
  end

  assign leds      = (estado_q == MOSTRA) ?
                     NUM_BOTOES'(indice_para_onehot(5'(mem_q[e_valor]))) : '0;
  assign pronto    = pronto_q;
  assign acertou   = acertou_q;
  assign errou     = errou_q;
  assign rodada    = rodada_q;
  assign db_estado = estado_q;
  assign db_jogada = jogada_q;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Self-checking bench for jogo_memoria_param: a sequence queue models the game and predicts
// LED playback, state codes and final flags for directed and randomized games.
module tb_jogo_memoria_param;

  localparam int NB = 4;
  localparam int MR = 3;
  localparam int TC = 20;
  localparam int LC = 4;
  localparam int RW = $clog2(MR + 1);

  logic          clock = 1'b0;
  logic          reset, jogar;
  logic [NB-1:0] botoes;
  logic [NB-1:0] leds;
  logic          pronto, acertou, errou, timeout;
  logic [RW-1:0] rodada;
  logic [4:0]    db_estado;
  logic [1:0]    db_jogada;

  int asserts  = 0;
  int failures = 0;
  int seq[$];

  always #5 clock = ~clock;

  jogo_memoria_param #(
    .NUM_BOTOES(NB), .MAX_RODADAS(MR), .TIMEOUT_CICLOS(TC), .LED_CICLOS(LC)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes), .leds(leds),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .rodada(rodada), .db_estado(db_estado), .db_jogada(db_jogada)
  );

  function automatic logic [NB-1:0] oh(input int i);
    logic [NB-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic reset_dut();
    reset = 1'b1; jogar = 1'b0; botoes = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    seq.delete();
  endtask

  task automatic start_game();
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
    @(negedge clock);
    asserts++;
    if (db_estado !== 5'd2) begin
      failures++; $display("[TB] FAIL start_state: got %0d expected 2", db_estado);
    end
    seq.delete();
  endtask

  // Appends a move, then expects the whole sequence replayed with exact LED timing.
  task automatic append_move(input int idx, input logic [NB-1:0] hold);
    seq.push_back(idx);
    botoes = oh(idx);
    @(negedge clock);
    botoes = '0;
    @(negedge clock);
    asserts++;
    if (db_estado !== 5'd3) begin
      failures++; $display("[TB] FAIL grava_state: got %0d expected 3", db_estado);
    end
    @(negedge clock);
    for (int i = 0; i < seq.size(); i++) begin
      for (int c = 0; c < LC; c++) begin
        asserts++;
        if (leds !== oh(seq[i])) begin
          failures++; $display("[TB] FAIL led_on[%0d]: got %b expected %b", i, leds, oh(seq[i]));
        end
        @(negedge clock);
      end
      if (i == seq.size() - 1) botoes = hold;
      for (int c = 0; c < LC; c++) begin
        asserts++;
        if (leds !== '0) begin
          failures++; $display("[TB] FAIL led_off[%0d]: got %b expected 0", i, leds);
        end
        @(negedge clock);
      end
    end
    asserts++;
    if (db_estado !== 5'd6) begin
      failures++; $display("[TB] FAIL espera_jogada: got %0d expected 6", db_estado);
    end
    asserts++;
    if (rodada !== RW'(seq.size())) begin
      failures++; $display("[TB] FAIL rodada: got %0d expected %0d", rodada, seq.size());
    end
  endtask

  // Repeats the sequence; at position bad_pos the pattern bad_pat replaces the right button.
  task automatic repeat_moves(input int bad_pos, input logic [NB-1:0] bad_pat);
    int esperado;
    for (int i = 0; i < seq.size(); i++) begin
      botoes = (i == bad_pos) ? bad_pat : oh(seq[i]);
      @(negedge clock);
      botoes = '0;
      @(negedge clock);
      asserts++;
      if (db_estado !== 5'd7) begin
        failures++; $display("[TB] FAIL compara_latency: got %0d expected 7", db_estado);
      end
      @(negedge clock);
      if (i == bad_pos) esperado = 9;
      else if (i < seq.size() - 1) esperado = 6;
      else if (seq.size() == MR) esperado = 8;
      else esperado = 2;
      asserts++;
      if (db_estado !== 5'(esperado)) begin
        failures++; $display("[TB] FAIL after_repeat[%0d]: got %0d expected %0d", i, db_estado, esperado);
      end
      if (esperado == 9 || esperado == 8) begin
        asserts++;
        if ({pronto, acertou, errou, timeout} !== {1'b1, esperado == 8, esperado == 9, 1'b0}) begin
          failures++;
          $display("[TB] FAIL final_flags: got %b expected %b", {pronto, acertou, errou, timeout},
                   {1'b1, esperado == 8, esperado == 9, 1'b0});
        end
        asserts++;
        if (leds !== '0) begin
          failures++; $display("[TB] FAIL final_leds: got %b expected 0", leds);
        end
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; jogar = 1'b0; botoes = '0;
    @(negedge clock);
    asserts++;
    if ({leds, pronto, acertou, errou, timeout, rodada, db_estado} !== '0) begin
      failures++; $display("[TB] FAIL reset_outputs: got %b expected 0",
                           {leds, pronto, acertou, errou, timeout, rodada, db_estado});
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    asserts++;
    if (db_estado !== 5'd0) begin
      failures++; $display("[TB] FAIL idle_without_jogar: got %0d expected 0", db_estado);
    end
  endtask

  task automatic test_first_round_and_win();
    start_game();
    append_move(1, '0);
    repeat_moves(-1, '0);
    append_move(3, '0);
    repeat_moves(-1, '0);
    append_move(0, '0);
    repeat_moves(-1, '0);
    asserts++;
    if (rodada !== RW'(MR)) begin
      failures++; $display("[TB] FAIL win_rodada: got %0d expected %0d", rodada, MR);
    end
  endtask

  task automatic test_wrong_move();
    reset_dut();
    start_game();
    append_move(1, '0);
    repeat_moves(-1, '0);
    append_move(3, '0);
    repeat_moves(1, 4'b0100);
  endtask

  task automatic test_timeout();
    reset_dut();
    start_game();
    append_move(2, '0);
`ifdef JOGO_TIMEOUT_EN
    repeat (TC - 1) @(negedge clock);
    asserts++;
    if (db_estado !== 5'd6) begin
      failures++; $display("[TB] FAIL timeout_early: got %0d expected 6", db_estado);
    end
    @(negedge clock);
    asserts++;
    if ({db_estado, pronto, errou, timeout, acertou} !== {5'd10, 4'b1110}) begin
      failures++; $display("[TB] FAIL timeout_flags: got %0d %b expected 10 1110",
                           db_estado, {pronto, errou, timeout, acertou});
    end
`else
    repeat (100) @(negedge clock);
    asserts++;
    if ({db_estado, pronto, timeout} !== {5'd6, 2'b00}) begin
      failures++; $display("[TB] FAIL no_timeout_wait: got %0d %b expected 6 00",
                           db_estado, {pronto, timeout});
    end
`endif
  endtask

  task automatic test_bad_inputs();
    reset_dut();
    start_game();
    botoes = 4'b0110;
    @(negedge clock);
    botoes = '0;
    @(negedge clock);
    asserts++;
    if ({db_estado, pronto, errou, timeout} !== {5'd9, 3'b110}) begin
      failures++; $display("[TB] FAIL multi_press: got %0d %b expected 9 110",
                           db_estado, {pronto, errou, timeout});
    end
    reset_dut();
    start_game();
    append_move(0, 4'b0010);
    repeat (5) @(negedge clock);
    asserts++;
    if (db_estado !== 5'd6) begin
      failures++; $display("[TB] FAIL held_button: got %0d expected 6", db_estado);
    end
    botoes = '0;
    @(negedge clock);
    repeat_moves(-1, '0);
  endtask

  task automatic test_reset_mid_game();
    reset_dut();
    start_game();
    botoes = oh(2);
    @(negedge clock);
    botoes = '0;
    repeat (2) @(negedge clock);
    asserts++;
    if (leds !== oh(2)) begin
      failures++; $display("[TB] FAIL mostra_before_reset: got %b expected %b", leds, oh(2));
    end
    #2 reset = 1'b1;
    jogar = 1'b1;
    #1;
    asserts++;
    if ({leds, pronto, errou, rodada, db_estado} !== '0) begin
      failures++; $display("[TB] FAIL async_reset: got %b expected 0",
                           {leds, pronto, errou, rodada, db_estado});
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    jogar = 1'b0;
    asserts++;
    if (db_estado !== 5'd1) begin
      failures++; $display("[TB] FAIL jogar_at_release: got %0d expected 1", db_estado);
    end
    reset_dut();
    start_game();
    append_move(2, '0);
    repeat_moves(0, oh(3));
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
    asserts++;
    if ({db_estado, pronto, errou, rodada} !== {5'd1, 2'b00, RW'(0)}) begin
      failures++; $display("[TB] FAIL restart_from_erro: got %0d %b rodada %0d expected 1 00 0",
                           db_estado, {pronto, errou}, rodada);
    end
    @(negedge clock);
    asserts++;
    if (db_estado !== 5'd2) begin
      failures++; $display("[TB] FAIL restart_espera: got %0d expected 2", db_estado);
    end
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 8; g++) begin
      int bad_round;
      reset_dut();
      start_game();
      bad_round = $urandom_range(1, MR + 1);
      for (int r = 1; r <= MR; r++) begin
        append_move($urandom_range(0, NB - 1), '0);
        if (r == bad_round) begin
          int pos, k;
          logic [NB-1:0] pat;
          pos = $urandom_range(0, r - 1);
          k   = (seq[pos] + 1 + $urandom_range(0, NB - 2)) % NB;
          pat = oh(k);
          if ($urandom_range(0, 1) == 1) pat = pat | oh(seq[pos]);
          repeat_moves(pos, pat);
          break;
        end
        repeat_moves(-1, '0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_round_and_win();
    test_wrong_move();
    test_timeout();
    test_bad_inputs();
    test_reset_mid_game();
    test_random_games();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
